// File: rtl/video_tp_gen_axis.sv
// AXI4-Stream video test-pattern source: WxH frames with programmable
// H/V blanking, selectable pattern, SOF on TUSER, EOL on TLAST.
module video_tp_gen_axis #(
    parameter int DW  = 16,
    parameter int CW  = 12,
    parameter int BW  = 24,
    parameter int FCW = 8
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            cfg_en_i,
    input  logic [2:0]      cfg_mode_i,
    input  logic [CW-1:0]   cfg_width_i,
    input  logic [CW-1:0]   cfg_height_i,
    input  logic [15:0]     cfg_hblank_i,
    input  logic [BW-1:0]   cfg_vblank_i,
    input  logic [FCW-1:0]  cfg_num_frames_i,
    output logic [DW-1:0]   m_axis_tdata,
    output logic [DW/8-1:0] m_axis_tkeep,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tlast,
    output logic            m_axis_tuser,
    output logic [FCW-1:0]  frame_cnt_o,
    output logic [31:0]     stall_cnt_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_err_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACTIVE = 3'd1;
    localparam logic [2:0] S_HBLANK = 3'd2;
    localparam logic [2:0] S_VBLANK = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic [DW-1:0]  pix_q, pix_d;
    logic [CW-1:0]  bpos_q, bpos_d;
    logic [2:0]     bar_q, bar_d;
    logic [BW-1:0]  blank_q, blank_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [FCW-1:0] run_cnt_q, run_cnt_d;
    logic [31:0]    stall_q, stall_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [2:0]     sh_mode_q, sh_mode_d;
    logic [CW-1:0]  sh_width_q, sh_width_d;
    logic [CW-1:0]  sh_height_q, sh_height_d;
    logic [15:0]    sh_hblank_q, sh_hblank_d;
    logic [BW-1:0]  sh_vblank_q, sh_vblank_d;
    logic [FCW-1:0] sh_nf_q, sh_nf_d;

    logic           tvalid, xfer, frame_end, start;
    logic [CW-1:0]  bar_w;
    logic [DW-1:0]  pattern;

    assign tvalid = (state_q == S_ACTIVE);
    assign xfer   = tvalid && m_axis_tready;
    assign bar_w  = sh_width_q >> 3;

    // Pattern value for the beat currently presented (x/y/pix/bar are frozen while stalled)
    always_comb begin
        pattern = '0;
        case (sh_mode_q)
            3'd1:    pattern[DW-1 -: 3] = bar_q;
            3'd2:    pattern = (x_q[3] ^ y_q[3]) ? '1 : '0;
            3'd3:    pattern = DW'(x_q);
            3'd4:    pattern = DW'(frame_cnt_q);
            default: pattern = pix_q;
        endcase
    end

    // Frame/line sequencing, blanking timers, pattern counters and status
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pix_d       = pix_q;
        bpos_d      = bpos_q;
        bar_d       = bar_q;
        blank_d     = blank_q;
        frame_cnt_d = frame_cnt_q;
        run_cnt_d   = run_cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        sh_mode_d   = sh_mode_q;
        sh_width_d  = sh_width_q;
        sh_height_d = sh_height_q;
        sh_hblank_d = sh_hblank_q;
        sh_vblank_d = sh_vblank_q;
        sh_nf_d     = sh_nf_q;
        frame_end   = 1'b0;
        start       = 1'b0;
        stall_d     = (tvalid && !m_axis_tready && stall_q != '1) ? stall_q + 32'd1 : stall_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_en_i) begin
                    if (cfg_width_i == '0 || cfg_height_i == '0) begin
                        err_d = 1'b1;
                    end else begin
                        run_cnt_d = '0;
                        start     = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (xfer) begin
                    pix_d = pix_q + DW'(1);
                    if (x_q == sh_width_q - CW'(1)) begin
                        x_d    = '0;
                        bpos_d = '0;
                        bar_d  = '0;
                        if (y_q == sh_height_q - CW'(1)) begin
                            y_d = '0;
                            if (sh_vblank_q == '0) begin
                                frame_end = 1'b1;
                            end else begin
                                state_d = S_VBLANK;
                                blank_d = '0;
                            end
                        end else begin
                            y_d = y_q + CW'(1);
                            if (sh_hblank_q != '0) begin
                                state_d = S_HBLANK;
                                blank_d = '0;
                            end
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                        // Bar index advances every bar_w pixels and sticks at 7
                        if (bar_w != '0) begin
                            if (bpos_q == bar_w - CW'(1)) begin
                                bpos_d = '0;
                                if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
                            end else begin
                                bpos_d = bpos_q + CW'(1);
                            end
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (blank_q + BW'(1) == BW'(sh_hblank_q)) state_d = S_ACTIVE;
                else                                      blank_d = blank_q + BW'(1);
            end
            S_VBLANK: begin
                if (blank_q + BW'(1) == sh_vblank_q) frame_end = 1'b1;
                else                                 blank_d   = blank_q + BW'(1);
            end
            S_DONE: begin
                if (!cfg_en_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // End of frame can come from VBLANK expiry or directly from the last beat when vblank==0
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
            run_cnt_d   = run_cnt_q + FCW'(1);
            if (sh_nf_q != '0 && run_cnt_q + FCW'(1) == sh_nf_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else if (!cfg_en_i) begin
                state_d = S_IDLE;
            end else if (cfg_width_i == '0 || cfg_height_i == '0) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                start = 1'b1;
            end
        end

        if (start) begin
            sh_mode_d   = cfg_mode_i;
            sh_width_d  = cfg_width_i;
            sh_height_d = cfg_height_i;
            sh_hblank_d = cfg_hblank_i;
            sh_vblank_d = cfg_vblank_i;
            sh_nf_d     = cfg_num_frames_i;
            x_d         = '0;
            y_d         = '0;
            pix_d       = '0;
            bpos_d      = '0;
            bar_d       = '0;
            state_d     = S_ACTIVE;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            pix_q       <= '0;
            bpos_q      <= '0;
            bar_q       <= '0;
            blank_q     <= '0;
            frame_cnt_q <= '0;
            run_cnt_q   <= '0;
            stall_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sh_mode_q   <= '0;
            sh_width_q  <= '0;
            sh_height_q <= '0;
            sh_hblank_q <= '0;
            sh_vblank_q <= '0;
            sh_nf_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_q       <= pix_d;
            bpos_q      <= bpos_d;
            bar_q       <= bar_d;
            blank_q     <= blank_d;
            frame_cnt_q <= frame_cnt_d;
            run_cnt_q   <= run_cnt_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sh_mode_q   <= sh_mode_d;
            sh_width_q  <= sh_width_d;
            sh_height_q <= sh_height_d;
            sh_hblank_q <= sh_hblank_d;
            sh_vblank_q <= sh_vblank_d;
            sh_nf_q     <= sh_nf_d;
        end
    end

    assign m_axis_tvalid = tvalid;
    assign m_axis_tdata  = tvalid ? pattern : '0;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = tvalid && (x_q == sh_width_q - CW'(1));
    assign m_axis_tuser  = tvalid && (x_q == '0) && (y_q == '0);
    assign frame_cnt_o   = frame_cnt_q;
    assign stall_cnt_o   = stall_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = done_q;
    assign cfg_err_o     = err_q;

endmodule

// File: tb/tb_video_tp_gen_axis.sv
// Bench for video_tp_gen_axis: expected beats come from a per-pixel frame model.
module tb_video_tp_gen_axis;

    localparam int DW  = 16;
    localparam int CW  = 12;
    localparam int BW  = 24;
    localparam int FCW = 8;

    typedef logic [DW+1:0] beat_t;   // {tuser, tlast, tdata}

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            cfg_en_i = 1'b0;
    logic [2:0]      cfg_mode_i = '0;
    logic [CW-1:0]   cfg_width_i = '0;
    logic [CW-1:0]   cfg_height_i = '0;
    logic [15:0]     cfg_hblank_i = '0;
    logic [BW-1:0]   cfg_vblank_i = '0;
    logic [FCW-1:0]  cfg_num_frames_i = '0;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [FCW-1:0]  frame_cnt_o;
    logic [31:0]     stall_cnt_o;
    logic            busy_o;
    logic            done_o;
    logic            cfg_err_o;

    video_tp_gen_axis #(.DW(DW), .CW(CW), .BW(BW), .FCW(FCW)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i), .cfg_hblank_i(cfg_hblank_i),
        .cfg_vblank_i(cfg_vblank_i), .cfg_num_frames_i(cfg_num_frames_i),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_cnt_o(frame_cnt_o), .stall_cnt_o(stall_cnt_o), .busy_o(busy_o),
        .done_o(done_o), .cfg_err_o(cfg_err_o)
    );

    always #5 ACLK = ~ACLK;

    int          n_pass = 0;
    int          n_total = 0;
    beat_t       exp_q[$];
    beat_t       act_q[$];
    int          cyc_q[$];
    int          cyc = 0;
    int          stalls_seen = 0;
    int          done_seen = 0;
    bit          prev_stall = 1'b0;
    logic [DW+2:0] prev_beat = '0;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Model: one frame of beats from the pattern rules, pixel by pixel
    task automatic gen_frame(input int w, input int h, input int mode, input int fid);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                int bw;
                int k;
                logic [DW-1:0] d;
                bw = w / 8;
                case (mode)
                    1: begin
                        k = (bw == 0) ? 0 : x / bw;
                        if (k > 7) k = 7;
                        d = DW'(k) << (DW - 3);
                    end
                    2: d = ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? '1 : '0;
                    3: d = DW'(x);
                    4: d = DW'(fid);
                    default: d = DW'(y * w + x);
                endcase
                exp_q.push_back({(x == 0 && y == 0), (x == w - 1), d});
            end
        end
    endtask

    task automatic mon_clear();
        act_q.delete();
        cyc_q.delete();
        stalls_seen = 0;
        done_seen = 0;
        prev_stall = 1'b0;
        cyc = 0;
    endtask

    // One clock: observe at the falling edge, drive tready just after the rising edge
    task automatic step();
        @(negedge ACLK);
        cyc++;
        if (m_axis_tvalid && m_axis_tready) begin
            act_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            cyc_q.push_back(cyc);
        end
        if (prev_stall)
            check("hold", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && !m_axis_tready) stalls_seen++;
        if (done_o) done_seen++;
        @(posedge ACLK);
        #1;
        m_axis_tready = rand_ready ? (($urandom & 1) != 0) : 1'b1;
    endtask

    task automatic do_reset();
        cfg_en_i = 1'b0;
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        mon_clear();
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
    endtask

    task automatic run_frames(input int w, input int h, input int hb, input int vb,
                              input int mode, input int nf, input bit rnd, input string tag);
        int budget;
        int bad;
        do_reset();
        exp_q.delete();
        for (int f = 0; f < nf; f++) gen_frame(w, h, mode, f);
        cfg_width_i = CW'(w);
        cfg_height_i = CW'(h);
        cfg_hblank_i = 16'(hb);
        cfg_vblank_i = BW'(vb);
        cfg_mode_i = 3'(mode);
        cfg_num_frames_i = FCW'(nf);
        rand_ready = rnd;
        cfg_en_i = 1'b1;
        budget = nf * (w * h * 4 + h * (hb + 4) + vb + 10) + 50;
        for (int i = 0; i < budget && done_seen == 0; i++) step();
        repeat (4) step();
        compare_beats(tag);
        if (!rnd) begin
            bad = 0;
            for (int i = 1; i < cyc_q.size(); i++) begin
                int x;
                int y;
                int want;
                x = i % w;
                y = (i / w) % h;
                want = (x != 0) ? 1 : ((y != 0) ? hb + 1 : vb + 1);
                if (cyc_q[i] - cyc_q[i-1] != want) bad++;
            end
            check({tag, "_gaps"}, 64'(bad), 64'(0));
        end
        check({tag, "_done_pulses"}, 64'(done_seen), 64'(1));
        check({tag, "_frame_cnt"}, 64'(frame_cnt_o), 64'(nf % (1 << FCW)));
        check({tag, "_stall_cnt"}, 64'(stall_cnt_o), 64'(stalls_seen));
        check({tag, "_busy_in_done"}, 64'(busy_o), 64'(0));
        cfg_en_i = 1'b0;
        repeat (2) step();
        check({tag, "_idle_tvalid"}, 64'(m_axis_tvalid), 64'(0));
    endtask

    initial begin
        int budget;
        do_reset();

        // Reset values
        check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst_tkeep", 64'(m_axis_tkeep), 64'(2'b11));
        check("rst_tdata", 64'(m_axis_tdata), 64'(0));
        check("rst_tlast", 64'(m_axis_tlast), 64'(0));
        check("rst_tuser", 64'(m_axis_tuser), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt_o), 64'(0));
        check("rst_stall_cnt", 64'(stall_cnt_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_err", 64'(cfg_err_o), 64'(0));

        // T1 / T2: basic frame, then under random backpressure
        run_frames(8, 4, 2, 5, 0, 1, 1'b0, "t1");
        run_frames(8, 4, 2, 5, 0, 1, 1'b1, "t2");

        // T3: colour bars at two widths, plus checker and ramp
        run_frames(64, 2, 3, 4, 1, 1, 1'b0, "t3_bars64");
        run_frames(20, 1, 0, 0, 1, 1, 1'b0, "t3_bars20");
        run_frames(16, 16, 0, 2, 2, 1, 1'b1, "checker");
        run_frames(40, 2, 1, 1, 3, 1, 1'b0, "ramp");

        // Random configurations, modes and backpressure
        for (int r = 0; r < 4; r++)
            run_frames($urandom_range(24, 1), $urandom_range(5, 1), $urandom_range(3, 0),
                       $urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(2, 1),
                       1'b1, $sformatf("rnd%0d", r));

        // T4: continuous frame-id stream, enable dropped during frame 3
        do_reset();
        exp_q.delete();
        for (int f = 0; f < 3; f++) gen_frame(4, 2, 4, f);
        cfg_width_i = CW'(4);
        cfg_height_i = CW'(2);
        cfg_hblank_i = 16'd1;
        cfg_vblank_i = BW'(3);
        cfg_mode_i = 3'd4;
        cfg_num_frames_i = '0;
        cfg_en_i = 1'b1;
        for (int i = 0; i < 200 && frame_cnt_o != FCW'(2); i++) step();
        cfg_en_i = 1'b0;
        for (int i = 0; i < 200 && busy_o; i++) step();
        repeat (10) step();
        compare_beats("t4");
        check("t4_frame_cnt", 64'(frame_cnt_o), 64'(3));
        check("t4_no_done", 64'(done_seen), 64'(0));
        check("t4_busy", 64'(busy_o), 64'(0));

        // T5: zero width with enable sets the sticky error
        do_reset();
        cfg_width_i = '0;
        cfg_height_i = CW'(4);
        cfg_en_i = 1'b1;
        repeat (4) step();
        check("t5_err", 64'(cfg_err_o), 64'(1));
        check("t5_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("t5_busy", 64'(busy_o), 64'(0));
        cfg_en_i = 1'b0;
        cfg_width_i = CW'(8);
        repeat (3) step();
        check("t5_err_sticky", 64'(cfg_err_o), 64'(1));
        do_reset();
        check("t5_err_cleared", 64'(cfg_err_o), 64'(0));

        // T6: asynchronous reset in the middle of a line of frame 2
        cfg_width_i = CW'(16);
        cfg_height_i = CW'(4);
        cfg_hblank_i = 16'd2;
        cfg_vblank_i = BW'(2);
        cfg_mode_i = 3'd0;
        cfg_num_frames_i = '0;
        rand_ready = 1'b1;
        cfg_en_i = 1'b1;
        budget = 1000;
        for (int i = 0; i < budget && act_q.size() < 64 + 5; i++) step();
        check("t6_reached_frame2", 64'(frame_cnt_o), 64'(1));
        ARESET = 1'b1;
        #1;
        check("t6_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("t6_frame_cnt", 64'(frame_cnt_o), 64'(0));
        check("t6_stall_cnt", 64'(stall_cnt_o), 64'(0));
        check("t6_busy", 64'(busy_o), 64'(0));
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        mon_clear();
        for (int i = 0; i < 20 && act_q.size() == 0; i++) step();
        check("t6_restart_beats", 64'(act_q.size() > 0), 64'(1));
        if (act_q.size() > 0)
            check("t6_restart_sof", 64'(act_q[0]), 64'({1'b1, 1'b0, 16'h0000}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
